// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - iterative shift-and-add unsigned multiplier with valid/ready handshakes
// Also holds prefix_tree_adder, the Kogge-Stone adder used for the accumulate step.

module prefix_tree_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   localparam int L = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0] w_g [0:L];
   logic [N-1:0] w_p [0:L];
   logic [N:0]   w_c;

   assign w_g[0] = a & b;
   assign w_p[0] = a ^ b;

   // After level l, w_g/w_p at bit i cover the span [i-2^(l+1)+1 : i].
   genvar gl, gi;
   generate
      for (gl = 0; gl < L; gl++) begin : g_level
         for (gi = 0; gi < N; gi++) begin : g_bit
            if (gi >= (1 << gl)) begin : g_merge
               assign w_g[gl+1][gi] = w_g[gl][gi] | (w_p[gl][gi] & w_g[gl][gi-(1<<gl)]);
               assign w_p[gl+1][gi] = w_p[gl][gi] & w_p[gl][gi-(1<<gl)];
            end else begin : g_pass
               assign w_g[gl+1][gi] = w_g[gl][gi];
               assign w_p[gl+1][gi] = w_p[gl][gi];
            end
         end
      end
      for (gi = 0; gi < N; gi++) begin : g_carry
         assign w_c[gi+1] = w_g[L][gi] | (w_p[L][gi] & cin);
      end
   endgenerate

   assign w_c[0] = cin;
   assign sum    = w_p[0] ^ w_c[N-1:0];
   assign cout   = w_c[N];
endmodule

module mult_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] res,
   output logic               busy
);
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;

   logic [WIDTH-1:0]   w_b_shift;
   logic [2*WIDTH-1:0] w_a_shift;
   logic [2*WIDTH-1:0] w_pp;
   logic [2*WIDTH-1:0] w_sum;

   assign w_b_shift = r_b >> r_cnt;
   assign w_a_shift = {{WIDTH{1'b0}}, r_a} << r_cnt;
   assign w_pp      = w_b_shift[0] ? w_a_shift : '0;

   prefix_tree_adder #(.N(2*WIDTH)) u_adder (
      .a    (r_acc),
      .b    (w_pp),
      .cin  (1'b0),
      .sum  (w_sum),
      .cout ()
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
   assign res       = r_acc;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - directed and sweep checks for mult_sequencer (WIDTH=4)

module tb_mult_sequencer;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] res;
   logic       busy;

   int total;
   int bad;

   mult_sequencer #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents a pair at the next edge and drops in_valid 1 ns after it.
   task automatic start_op(input logic [3:0] ta, input logic [3:0] tb);
      in_valid = 1'b1;
      a = ta;
      b = tb;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts edges after the handshake until out_valid rises; 0 means timeout.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = 4'd0;
      b = 4'd0;
      #12;
      total++;
      if ({in_ready, out_valid, busy, res} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
         bad++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b res=%0d want 1 0 0 0", in_ready, out_valid, busy, res);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic;
      int lat;
      start_op(4'd3, 4'd5);
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL basic_run_flags: got busy=%b rdy=%b want 1 0", busy, in_ready);
      end
      wait_done(lat);
      total++;
      if (lat !== 4) begin
         bad++;
         $display("FAIL basic_latency: got %0d want 4", lat);
      end
      total++;
      if (res !== 8'd15) begin
         bad++;
         $display("FAIL basic_res: got %0d want 15", res);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_return_idle: got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
      end
   endtask

   task automatic test_corners;
      int lat;
      start_op(4'd15, 4'd15);
      wait_done(lat);
      total++;
      if (res !== 8'hE1) begin
         bad++;
         $display("FAIL max_res: got %0h want e1", res);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      start_op(4'd0, 4'd9);
      wait_done(lat);
      total++;
      if (lat !== 4) begin
         bad++;
         $display("FAIL zero_latency: got %0d want 4", lat);
      end
      total++;
      if (res !== 8'd0) begin
         bad++;
         $display("FAIL zero_res: got %0d want 0", res);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_stall;
      int lat;
      start_op(4'd7, 4'd6);
      wait_done(lat);
      for (int s = 0; s < 5; s++) begin
         @(posedge clk);
         #1;
         total++;
         if (res !== 8'd42 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold[%0d]: got res=%0d vld=%b want 42 1", s, res, out_valid);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL stall_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_ignore_input;
      int lat;
      in_valid = 1'b1;
      a = 4'd2;
      b = 4'd3;
      @(posedge clk);
      #1;
      a = 4'd1;
      b = 4'd1;
      wait_done(lat);
      total++;
      if (res !== 8'd6 || lat !== 4) begin
         bad++;
         $display("FAIL ignore_first: got res=%0d lat=%0d want 6 4", res, lat);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL ignore_idle: got rdy=%b want 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done(lat);
      total++;
      if (res !== 8'd1 || lat !== 4) begin
         bad++;
         $display("FAIL ignore_second: got res=%0d lat=%0d want 1 4", res, lat);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset;
      int lat;
      start_op(4'd9, 4'd11);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({in_ready, out_valid, busy, res} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
         bad++;
         $display("FAIL async_reset: got rdy=%b vld=%b busy=%b res=%0d want 1 0 0 0", in_ready, out_valid, busy, res);
      end
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_op(4'd9, 4'd11);
      wait_done(lat);
      total++;
      if (res !== 8'd99 || lat !== 4) begin
         bad++;
         $display("FAIL after_reset: got res=%0d lat=%0d want 99 4", res, lat);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_sweep;
      int lat;
      int stall;
      int handshakes;
      logic [7:0] exp;
      handshakes = 0;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            exp = 8'(ia * ib);
            start_op(4'(ia), 4'(ib));
            wait_done(lat);
            total++;
            if (lat == 0 || res !== exp) begin
               bad++;
               $display("FAIL sweep %0d*%0d: got res=%0d lat=%0d want %0d", ia, ib, res, lat, exp);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
               @(posedge clk);
               #1;
               if (out_valid !== 1'b1 || res !== exp) begin
                  total++;
                  bad++;
                  $display("FAIL sweep_stall %0d*%0d: got vld=%b res=%0d want 1 %0d", ia, ib, out_valid, res, exp);
               end
            end
            out_ready = 1'b1;
            @(posedge clk);
            if (out_valid && out_ready) handshakes++;
            #1;
            out_ready = 1'b0;
            if (out_valid !== 1'b0) begin
               total++;
               bad++;
               $display("FAIL sweep_single %0d*%0d: got vld=%b want 0", ia, ib, out_valid);
            end
         end
      end
      total++;
      if (handshakes !== 256) begin
         bad++;
         $display("FAIL sweep_count: got %0d want 256", handshakes);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_basic();
      test_corners();
      test_stall();
      test_ignore_input();
      test_async_reset();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
